// File: rtl/hazard_fwd.sv
// hazard_fwd: EX/MEM and MEM/WB operand forwarding unit with optional forwarding-event counters.
// Optional feature macro: HAZARD_FWD_STATS_EN (defined -> saturating event counters compiled in;
// undefined -> counter outputs tied to zero, operand behaviour unchanged).
module hazard_fwd #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   input  logic [XLEN-1:0]       rs1_val_in,
   input  logic [XLEN-1:0]       rs2_val_in,
   input  logic                  exmem_wb_en,
   input  logic [REG_ADDR_W-1:0] exmem_rd,
   input  logic [XLEN-1:0]       exmem_wb_data,
   input  logic                  exwb_wb_en,
   input  logic [REG_ADDR_W-1:0] exwb_rd,
   input  logic [XLEN-1:0]       exwb_wb_data,
   output logic [XLEN-1:0]       rs1_val_out,
   output logic [XLEN-1:0]       rs2_val_out,
   output logic [1:0]            rs1_fwd_sel,
   output logic [1:0]            rs2_fwd_sel,
   output logic [31:0]           fwd_cnt_exmem,
   output logic [31:0]           fwd_cnt_exwb
);

   localparam int unsigned SEL_W = 2;
   localparam int unsigned CNT_W = 32;
   localparam int unsigned INC_W = 2;

   localparam logic [SEL_W-1:0] SEL_RF    = 2'b00;
   localparam logic [SEL_W-1:0] SEL_EXMEM = 2'b01;
   localparam logic [SEL_W-1:0] SEL_EXWB  = 2'b10;

   logic rs1_hit_exmem, rs1_hit_exwb;
   logic rs2_hit_exmem, rs2_hit_exwb;

   // Stage-match detection; x0 is hardwired so a zero destination never matches.
   always_comb begin
      rs1_hit_exmem = exmem_wb_en && (exmem_rd != '0) && (exmem_rd == rs1_addr);
      rs1_hit_exwb  = exwb_wb_en  && (exwb_rd  != '0) && (exwb_rd  == rs1_addr);
      rs2_hit_exmem = exmem_wb_en && (exmem_rd != '0) && (exmem_rd == rs2_addr);
      rs2_hit_exwb  = exwb_wb_en  && (exwb_rd  != '0) && (exwb_rd  == rs2_addr);
   end

   // rs1 operand mux: the younger EX/MEM result wins over MEM/WB.
   always_comb begin
      rs1_val_out = rs1_val_in;
      rs1_fwd_sel = SEL_RF;
      if (rs1_hit_exmem) begin
         rs1_val_out = exmem_wb_data;
         rs1_fwd_sel = SEL_EXMEM;
      end else if (rs1_hit_exwb) begin
         rs1_val_out = exwb_wb_data;
         rs1_fwd_sel = SEL_EXWB;
      end
   end

   // rs2 operand mux, resolved independently of rs1.
   always_comb begin
      rs2_val_out = rs2_val_in;
      rs2_fwd_sel = SEL_RF;
      if (rs2_hit_exmem) begin
         rs2_val_out = exmem_wb_data;
         rs2_fwd_sel = SEL_EXMEM;
      end else if (rs2_hit_exwb) begin
         rs2_val_out = exwb_wb_data;
         rs2_fwd_sel = SEL_EXWB;
      end
   end

`ifdef HAZARD_FWD_STATS_EN
   logic [CNT_W-1:0] cnt_exmem_q, cnt_exmem_d;
   logic [CNT_W-1:0] cnt_exwb_q,  cnt_exwb_d;
   logic [INC_W-1:0] inc_exmem, inc_exwb;
   logic [CNT_W:0]   sum_exmem, sum_exwb;

   // Per-cycle forwarding events and saturating next-count.
   always_comb begin
      inc_exmem  = INC_W'(rs1_fwd_sel == SEL_EXMEM) + INC_W'(rs2_fwd_sel == SEL_EXMEM);
      inc_exwb   = INC_W'(rs1_fwd_sel == SEL_EXWB)  + INC_W'(rs2_fwd_sel == SEL_EXWB);
      sum_exmem  = {1'b0, cnt_exmem_q} + (CNT_W+1)'(inc_exmem);
      sum_exwb   = {1'b0, cnt_exwb_q}  + (CNT_W+1)'(inc_exwb);
      cnt_exmem_d = sum_exmem[CNT_W] ? '1 : sum_exmem[CNT_W-1:0];
      cnt_exwb_d  = sum_exwb[CNT_W]  ? '1 : sum_exwb[CNT_W-1:0];
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_exmem_q <= '0;
         cnt_exwb_q  <= '0;
      end else begin
         cnt_exmem_q <= cnt_exmem_d;
         cnt_exwb_q  <= cnt_exwb_d;
      end
   end

   assign fwd_cnt_exmem = cnt_exmem_q;
   assign fwd_cnt_exwb  = cnt_exwb_q;
`else
   // Statistics disabled: ports kept, driven constant.
   assign fwd_cnt_exmem = '0;
   assign fwd_cnt_exwb  = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd.sv
// Self-checking bench for hazard_fwd: scoreboarded operand checks plus counter checks.
module tb_hazard_fwd;

   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = 5;

   typedef struct packed {
      logic [XLEN-1:0] v1;
      logic [XLEN-1:0] v2;
      logic [1:0]      s1;
      logic [1:0]      s2;
   } exp_t;

   typedef struct packed {
      logic [AW-1:0]   a1;
      logic [AW-1:0]   a2;
      logic [XLEN-1:0] r1;
      logic [XLEN-1:0] r2;
      logic            xe;
      logic [AW-1:0]   xrd;
      logic [XLEN-1:0] xd;
      logic            we;
      logic [AW-1:0]   wrd;
      logic [XLEN-1:0] wd;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [AW-1:0]   rs1_addr, rs2_addr;
   logic [XLEN-1:0] rs1_val_in, rs2_val_in;
   logic            exmem_wb_en, exwb_wb_en;
   logic [AW-1:0]   exmem_rd, exwb_rd;
   logic [XLEN-1:0] exmem_wb_data, exwb_wb_data;
   logic [XLEN-1:0] rs1_val_out, rs2_val_out;
   logic [1:0]      rs1_fwd_sel, rs2_fwd_sel;
   logic [31:0]     fwd_cnt_exmem, fwd_cnt_exwb;

   exp_t        sb_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] m_ex, m_wb;

   hazard_fwd #(.XLEN(XLEN), .REG_ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_val_in(rs1_val_in), .rs2_val_in(rs2_val_in),
      .exmem_wb_en(exmem_wb_en), .exmem_rd(exmem_rd), .exmem_wb_data(exmem_wb_data),
      .exwb_wb_en(exwb_wb_en), .exwb_rd(exwb_rd), .exwb_wb_data(exwb_wb_data),
      .rs1_val_out(rs1_val_out), .rs2_val_out(rs2_val_out),
      .rs1_fwd_sel(rs1_fwd_sel), .rs2_fwd_sel(rs2_fwd_sel),
      .fwd_cnt_exmem(fwd_cnt_exmem), .fwd_cnt_exwb(fwd_cnt_exwb)
   );

   always #5 clk = ~clk;

   // Reference for one operand: EX/MEM first, then MEM/WB, else register file; x0 never forwards.
   function automatic void pick(input logic [AW-1:0] a, input logic [XLEN-1:0] rf,
                                output logic [XLEN-1:0] v, output logic [1:0] s);
      if (exmem_wb_en && exmem_rd != 0 && exmem_rd == a) begin
         v = exmem_wb_data; s = 2'b01;
      end else if (exwb_wb_en && exwb_rd != 0 && exwb_rd == a) begin
         v = exwb_wb_data;  s = 2'b10;
      end else begin
         v = rf;            s = 2'b00;
      end
   endfunction

   function automatic logic [31:0] sat_add(input logic [31:0] c, input int n);
      logic [32:0] s;
      s = {1'b0, c} + 33'(n);
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   // Counter reference model, advanced on the same edges as the DUT.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ex = '0;
         m_wb = '0;
      end else begin
         logic [XLEN-1:0] v;
         logic [1:0]      s1, s2;
         pick(rs1_addr, rs1_val_in, v, s1);
         pick(rs2_addr, rs2_val_in, v, s2);
         m_ex = sat_add(m_ex, int'(s1 == 2'b01) + int'(s2 == 2'b01));
         m_wb = sat_add(m_wb, int'(s1 == 2'b10) + int'(s2 == 2'b10));
      end
   end

   function automatic logic [31:0] exp_cnt(input logic [31:0] m);
`ifdef HAZARD_FWD_STATS_EN
      return m;
`else
      return 32'h0 & m;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive a vector and push its expected operands onto the scoreboard.
   task automatic drive(input vec_t t);
      exp_t e;
      rs1_addr = t.a1;   rs2_addr = t.a2;
      rs1_val_in = t.r1; rs2_val_in = t.r2;
      exmem_wb_en = t.xe; exmem_rd = t.xrd; exmem_wb_data = t.xd;
      exwb_wb_en = t.we;  exwb_rd = t.wrd;  exwb_wb_data = t.wd;
      pick(t.a1, t.r1, e.v1, e.s1);
      pick(t.a2, t.r2, e.v2, e.s2);
      sb_q.push_back(e);
   endtask

   // Pop the oldest expectation and compare it with the settled outputs.
   task automatic check_ops(input string tag);
      exp_t e;
      #1;
      n_tests++;
      assert (sb_q.size() > 0) else begin
         n_fail++;
         $error("FAIL %s_sb observed=empty expected=entry", tag);
      end
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk({tag, "_v1"}, rs1_val_out, e.v1);
         chk({tag, "_v2"}, rs2_val_out, e.v2);
         chk({tag, "_s1"}, 32'(rs1_fwd_sel), 32'(e.s1));
         chk({tag, "_s2"}, 32'(rs2_fwd_sel), 32'(e.s2));
      end
   endtask

   // One clock-aligned step: drive 2ns after the edge, check 1ns later.
   task automatic step(input string tag, input vec_t t);
      @(posedge clk);
      #2;
      drive(t);
      check_ops(tag);
   endtask

   function automatic vec_t mk(input int a1, input int a2, input logic [31:0] r1, input logic [31:0] r2,
                               input bit xe, input int xrd, input logic [31:0] xd,
                               input bit we, input int wrd, input logic [31:0] wd);
      vec_t t;
      t.a1 = AW'(a1); t.a2 = AW'(a2); t.r1 = r1; t.r2 = r2;
      t.xe = xe; t.xrd = AW'(xrd); t.xd = xd;
      t.we = we; t.wrd = AW'(wrd); t.wd = wd;
      return t;
   endfunction

   initial begin
      vec_t t;
      rst_n = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #3;
      check_ops("idle_rst");
      chk("rst_cnt_exmem", fwd_cnt_exmem, 32'h0);
      chk("rst_cnt_exwb",  fwd_cnt_exwb,  32'h0);
      // Operand path works while reset is held.
      drive(mk(3, 4, 32'h11111111, 32'h22222222, 1, 3, 32'hAAAAAAAA, 1, 3, 32'hBBBBBBBB));
      check_ops("in_rst_prio");
      chk("in_rst_v1_const", rs1_val_out, 32'hAAAAAAAA);
      @(negedge clk);
      rst_n = 1'b1;

      step("prio", mk(3, 4, 32'h11111111, 32'h22222222, 1, 3, 32'hAAAAAAAA, 1, 3, 32'hBBBBBBBB));
      chk("prio_sel1_const", 32'(rs1_fwd_sel), 32'h1);
      step("exwb_only", mk(5, 4, 32'h55555555, 32'h44444444, 0, 4, 32'hDDDDDDDD, 1, 4, 32'hCCCCCCCC));
      chk("exwb_v2_const", rs2_val_out, 32'hCCCCCCCC);
      chk("exwb_sel2_const", 32'(rs2_fwd_sel), 32'h2);
      step("x0", mk(0, 0, 32'h12345678, 32'h9ABCDEF0, 1, 0, 32'hAAAAAAAA, 1, 0, 32'hBBBBBBBB));
      chk("x0_v1_const", rs1_val_out, 32'h12345678);
      step("both_exmem", mk(9, 9, 32'h1, 32'h2, 1, 9, 32'hFEEDBEEF, 0, 9, 32'h0));
      step("split", mk(7, 8, 32'h1, 32'h2, 1, 8, 32'hA5A5A5A5, 1, 7, 32'h5A5A5A5A));
      step("rd31", mk(31, 1, 32'h3, 32'h4, 0, 31, 32'h0, 1, 31, 32'hFFFFFFFF));

      for (int i = 0; i < 1000; i++) begin
         int r;
         t.a1 = AW'($urandom_range(0, 31));
         t.a2 = AW'($urandom_range(0, 31));
         t.r1 = $urandom; t.r2 = $urandom;
         t.xd = $urandom; t.wd = $urandom;
         t.xe = 1'($urandom); t.we = 1'($urandom);
         r = $urandom_range(0, 3);
         t.xrd = (r == 0) ? t.a1 : (r == 1) ? t.a2 : AW'($urandom_range(0, 31));
         r = $urandom_range(0, 3);
         t.wrd = (r == 0) ? t.a1 : (r == 1) ? t.a2 : AW'($urandom_range(0, 31));
         step("rand", t);
      end
      step("quiet", mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
      chk("rand_cnt_exmem", fwd_cnt_exmem, exp_cnt(m_ex));
      chk("rand_cnt_exwb",  fwd_cnt_exwb,  exp_cnt(m_wb));

      // Reset pulse then three cycles of both operands hitting EX/MEM.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("pulse_cnt_exmem", fwd_cnt_exmem, 32'h0);
      chk("pulse_cnt_exwb",  fwd_cnt_exwb,  32'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++)
         step("hit3", mk(6, 6, 0, 0, 1, 6, 32'h600D600D, 1, 7, 32'h0));
      step("hold", mk(6, 6, 0, 0, 0, 6, 0, 0, 0, 0));
`ifdef HAZARD_FWD_STATS_EN
      chk("three_cnt_exmem", fwd_cnt_exmem, 32'd6);
`else
      chk("three_cnt_exmem", fwd_cnt_exmem, 32'd0);
`endif
      chk("three_cnt_exwb", fwd_cnt_exwb, 32'd0);
      chk("three_model", fwd_cnt_exmem, exp_cnt(m_ex));

`ifdef HAZARD_FWD_STATS_EN
      // Preload near the ceiling and keep hitting; count must stick at all-ones.
      force dut.cnt_exmem_q = 32'hFFFF_FFFD;
      #1;
      release dut.cnt_exmem_q;
      m_ex = 32'hFFFF_FFFD;
      for (int i = 0; i < 3; i++)
         step("sat", mk(6, 6, 0, 0, 1, 6, 32'h1, 0, 0, 0));
      step("sat_hold", mk(6, 6, 0, 0, 0, 6, 0, 0, 0, 0));
      chk("sat_cnt_exmem", fwd_cnt_exmem, 32'hFFFF_FFFF);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global time bound so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
